// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer
//   Receive-side byte buffer between the UART receiver and the register/bus
//   front-end. Completed bytes are stored in a first-word-fall-through FIFO.
//   A one-cycle acknowledge releases the receiver once its byte has been taken.
//
// Configuration macro:
//   UART_RX_OVERRUN_DROP_EN
//     defined     : a byte arriving with no space is dropped, `overrun` is set
//                   and the receiver is acknowledged at once.
//     not defined : lossless backpressure. The byte waits in a pending register
//                   until a slot frees up, and the acknowledge is held back
//                   until then. `overrun` is tied to 0.
//
// Parameters:
//   DEPTH  : FIFO entries (power of two, >= 2)
//   AW     : log2(DEPTH)
//   THRESH : irq asserts when count >= THRESH (1..DEPTH)
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   rx_byte_valid   byte-complete pulse from the receiver
//   rx_byte         received byte, valid with rx_byte_valid
//   rx_frame_err    frame-error pulse from the receiver (byte is not stored)
//   rx_byte_ack     one-cycle pulse back to the receiver: byte consumed
//   rd_en           pop the head entry (ignored when empty)
//   rd_data         head entry, valid whenever !empty
//   empty, full     FIFO status
//   count           number of stored entries, 0..DEPTH
//   irq             registered level interrupt (count >= THRESH or overrun)
//   overrun         sticky dropped-byte flag
//   err_cnt         saturating frame-error count
//   clr_status      clears overrun and err_cnt on the next edge
module uart_rx_buffer #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int THRESH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_byte_valid,
  input  logic [7:0]    rx_byte,
  input  logic          rx_frame_err,
  output logic          rx_byte_ack,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          irq,
  output logic          overrun,
  output logic [15:0]   err_cnt,
  input  logic          clr_status
);

  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH_C = (AW+1)'(THRESH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg, count_next;
  logic [7:0]      pend_reg, pend_next;
  logic [15:0]     err_cnt_reg, err_cnt_next;
  logic            irq_reg, irq_next;
  logic            overrun_next;
  logic            wr_en;
  logic [7:0]      wr_data;
  logic            do_pop;
  logic            space;
`ifdef UART_RX_OVERRUN_DROP_EN
  logic            drop;
  logic            overrun_reg;
`endif

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign do_pop = rd_en && (count_reg != '0);
  assign space  = (count_reg != DEPTH_C) || do_pop;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pend_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    wr_en      = 1'b0;
    wr_data    = rx_byte;
`ifdef UART_RX_OVERRUN_DROP_EN
    drop       = 1'b0;
`endif
    case (state_reg)
      // ACK behaves like IDLE for new arrivals; it only adds the ack pulse.
      IDLE, ACK: begin
        state_next = IDLE;
        if (rx_byte_valid) begin
          if (space) begin
            wr_en      = 1'b1;
            state_next = ACK;
          end else begin
`ifdef UART_RX_OVERRUN_DROP_EN
            drop       = 1'b1;
            state_next = ACK;
`else
            pend_next  = rx_byte;
            state_next = PEND;
`endif
          end
        end
      end
      // New arrivals are ignored here: the receiver is still held waiting.
      PEND: begin
        wr_data = pend_reg;
        if (space) begin
          wr_en      = 1'b1;
          state_next = ACK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rx_byte_ack = (state_reg == ACK);

  // ---------------------------------------------------------------- storage
  // No reset on the array: contents are meaningless once the pointers reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= wr_data;
  end

  always_comb begin
    case ({wr_en, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_C);
  assign count   = count_reg;
  // Forced to zero while empty so the read port has a defined reset value.
  assign rd_data = empty ? 8'h00 : mem[rd_ptr_reg];

  // ---------------------------------------------------------------- status
  always_comb begin
    if (clr_status)
      err_cnt_next = rx_frame_err ? 16'd1 : 16'd0;
    else if (rx_frame_err && (err_cnt_reg != 16'hFFFF))
      err_cnt_next = err_cnt_reg + 16'd1;
    else
      err_cnt_next = err_cnt_reg;
  end

`ifdef UART_RX_OVERRUN_DROP_EN
  // A drop in the same cycle as a clear wins.
  assign overrun_next = drop | (overrun_reg & ~clr_status);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun_reg <= 1'b0;
    else
      overrun_reg <= overrun_next;
  end

  assign overrun = overrun_reg;
`else
  assign overrun_next = 1'b0;
  assign overrun      = 1'b0;
`endif

  assign irq_next = (count_next >= THRESH_C) || overrun_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= 16'h0000;
      irq_reg     <= 1'b0;
    end else begin
      err_cnt_reg <= err_cnt_next;
      irq_reg     <= irq_next;
    end
  end

  assign err_cnt = err_cnt_reg;
  assign irq     = irq_reg;

endmodule
